// File: rtl/debounce_tick.sv
// debounce_tick: synchronize and debounce a switch level, emitting one-cycle rise/fall ticks
module debounce_tick #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic db_level,
    output logic rise_tick,
    output logic fall_tick
);
    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          s1_q, s2_q;
    logic          db_level_q, rise_q, fall_q;

    assign db_level  = db_level_q;
    assign rise_tick = rise_q;
    assign fall_tick = fall_q;

    // two-flop synchronizer; the FSM only ever looks at s2_q
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= sw;
            s2_q <= s1_q;
        end
    end

    // next state and stability count: a change must persist DB_CYCLES samples to be accepted
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ZERO: begin
                state_d = s2_q ? WAIT1 : ZERO;
                cnt_d   = s2_q ? CW'(1) : '0;
            end
            WAIT1: begin
                state_d = !s2_q ? ZERO : (cnt_q == CMAX) ? ONE : WAIT1;
                cnt_d   = (!s2_q || cnt_q == CMAX) ? '0 : cnt_q + CW'(1);
            end
            ONE: begin
                state_d = s2_q ? ONE : WAIT0;
                cnt_d   = s2_q ? '0 : CW'(1);
            end
            default: begin
                state_d = s2_q ? ONE : (cnt_q == CMAX) ? ZERO : WAIT0;
                cnt_d   = (s2_q || cnt_q == CMAX) ? '0 : cnt_q + CW'(1);
            end
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ZERO;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // registered outputs: level follows the accepted state, ticks mark accepted transitions
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_level_q <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
        end else begin
            db_level_q <= (state_d == ONE) || (state_d == WAIT0);
            rise_q     <= (state_q == WAIT1) && (state_d == ONE);
            fall_q     <= (state_q == WAIT0) && (state_d == ZERO);
        end
    end
endmodule

// File: tb/tb_debounce_tick.sv
// tb_debounce_tick: scoreboard bench for debounce_tick with a downstream tick counter
module tb_debounce_tick;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic reset, sw;
    logic db_level, rise_tick, fall_tick;
    logic [2:0] cnt_q;
    logic up = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    logic [2:0] exp_q[$];
    logic lvl_m;
    int run_m;

    debounce_tick #(.DB_CYCLES(DB)) dut (
        .clk(clk),
        .reset(reset),
        .sw(sw),
        .db_level(db_level),
        .rise_tick(rise_tick),
        .fall_tick(fall_tick)
    );

    always #5 clk = ~clk;

    // 3-bit up counter enabled by rise_tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else if (rise_tick) cnt_q <= up ? cnt_q + 3'd1 : cnt_q - 3'd1;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference: count consecutive raw samples that disagree with the accepted level;
    // DB of them flip the level, and the result appears two edges later (synchronizer)
    task automatic model_reset();
        lvl_m = 1'b0;
        run_m = 0;
        exp_q.delete();
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b000);
    endtask

    task automatic step(input logic v);
        logic r, f;
        @(negedge clk);
        sw = v;
        r = 1'b0;
        f = 1'b0;
        if (v != lvl_m) begin
            run_m++;
            if (run_m == DB) begin
                lvl_m = v;
                run_m = 0;
                r = v;
                f = !v;
            end
        end else begin
            run_m = 0;
        end
        exp_q.push_back({lvl_m, r, f});
        @(posedge clk);
        #1;
        chk("db/rise/fall", {5'd0, db_level, rise_tick, fall_tick}, {5'd0, exp_q.pop_front()});
    endtask

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk("async_reset", {5'd0, db_level, rise_tick, fall_tick}, 8'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        sw = 1'b0;
        model_reset();
        #1 chk("reset_state", {5'd0, db_level, rise_tick, fall_tick}, 8'd0);
        #9 reset = 1'b0;
        hold(1'b1, DB + 4);
        chk("clean_press_level", {7'd0, db_level}, 8'd1);
        hold(1'b0, DB + 4);
        chk("release_level", {7'd0, db_level}, 8'd0);
        step(1'b1); step(1'b0); step(1'b1); step(1'b0);
        hold(1'b0, DB + 4);
        chk("bounce_level", {7'd0, db_level}, 8'd0);
        step(1'b1); step(1'b0);
        hold(1'b1, DB + 4);
        chk("bounce_press_level", {7'd0, db_level}, 8'd1);
        step(1'b0); step(1'b1);
        hold(1'b0, DB + 4);
        hold(1'b1, DB + 4);
        rst_pulse();
        chk("reset_from_one", {7'd0, db_level}, 8'd0);
        hold(1'b0, DB + 4);
        hold(1'b1, 4);
        rst_pulse();
        hold(1'b0, DB + 6);
        hold(1'b1, DB + 1);
        rst_pulse();
        hold(1'b1, DB + 4);
        chk("rise_after_release", {7'd0, db_level}, 8'd1);
        hold(1'b0, DB + 4);
        for (int i = 0; i < 150; i++) begin
            logic v = 1'($urandom_range(0, 1));
            hold(v, $urandom_range(1, DB + 2));
        end
        hold(1'b0, DB + 4);
        rst_pulse();
        chk("counter_reset", {5'd0, cnt_q}, 8'd0);
        for (int p = 0; p < 5; p++) begin
            hold(1'b1, DB + 4);
            chk("counter_press", {5'd0, cnt_q}, 8'(p + 1));
            hold(1'b0, DB + 4);
        end
        chk("counter_final", {5'd0, cnt_q}, 8'd5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
